// File: rtl/mem_responder.sv
// Memory-side responder for the cpu load/store port: a local word array
// answered after a fixed number of wait states with a one-cycle ready strobe.
module mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr_in,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_read_enable,
  input  logic                  i_write_enable,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_cache_ready,
  output logic                  o_err,
  output logic                  o_busy
);

  // state   | meaning
  // ST_IDLE | waiting for a read/write request level
  // ST_WAIT | wait states counting down on the latched request
  // ST_RESP | cache_ready (and err) presented for one cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_is_rd;
  logic                  r_is_wr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_cache_ready;
  logic                  r_err;
  logic                  r_busy;

  logic                  w_req;
  logic                  w_in_idle;
  logic [ADDR_WIDTH-1:0] w_cur_addr;
  logic                  w_cur_rd;
  logic                  w_cur_wr;
  logic                  w_cur_err;
  logic [DEPTH_LOG2-1:0] w_cur_idx;
  logic                  w_lat_err;
  logic [DEPTH_LOG2-1:0] w_lat_idx;
  logic                  w_enter_resp;
  logic                  w_commit;
  logic                  w_mem_we;

  assign w_req     = i_read_enable | i_write_enable;
  assign w_in_idle = (r_state == ST_IDLE);

  // With no wait states the request is decoded straight from the inputs.
  assign w_cur_addr = w_in_idle ? i_addr_in      : r_addr;
  assign w_cur_rd   = w_in_idle ? i_read_enable  : r_is_rd;
  assign w_cur_wr   = w_in_idle ? i_write_enable : r_is_wr;
  assign w_cur_err  = (|(w_cur_addr >> DEPTH_LOG2)) | (w_cur_rd & w_cur_wr);
  assign w_cur_idx  = w_cur_addr[DEPTH_LOG2-1:0];

  assign w_lat_err  = (|(r_addr >> DEPTH_LOG2)) | (r_is_rd & r_is_wr);
  assign w_lat_idx  = r_addr[DEPTH_LOG2-1:0];

  assign w_enter_resp = (r_state != ST_RESP) && (w_next_state == ST_RESP);

  // Writes retire from registered request fields only, so an asserted reset
  // (which forces r_state to IDLE) can never let a write reach the array.
  // Without wait states that means retiring as RESP is left.
  assign w_commit = (LATENCY == 0) ? (r_state == ST_RESP)
                                   : ((r_state == ST_WAIT) && (r_cnt == '0));
  assign w_mem_we = w_commit & r_is_wr & ~w_lat_err;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_next_state = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_rd <= 1'b0;
      r_is_wr <= 1'b0;
    end else begin
      if (w_in_idle && w_req) begin
        r_cnt   <= CNT_INIT;
        r_addr  <= i_addr_in;
        r_wdata <= i_wr_data;
        r_is_rd <= i_read_enable;
        r_is_wr <= i_write_enable;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rd_data     <= '0;
      r_cache_ready <= 1'b0;
      r_err         <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_cache_ready <= w_enter_resp;
      r_err         <= w_enter_resp & w_cur_err;
      r_busy        <= (w_next_state != ST_IDLE);
      if (w_enter_resp && w_cur_rd) begin
        r_rd_data <= w_cur_err ? '0 : r_mem[w_cur_idx];
      end
    end
  end

  // Array contents survive reset by design.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_lat_idx] <= r_wdata;
    end
  end

  assign o_rd_data     = r_rd_data;
  assign o_cache_ready = r_cache_ready;
  assign o_err         = r_err;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with two wait states and
// one with none, sharing clock and reset.
module tb_mem_responder;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en [2];
  logic        wr_en [2];
  logic [15:0] addr  [2];
  logic [31:0] wdat  [2];
  logic [31:0] rdat  [2];
  logic        rdy   [2];
  logic        err   [2];
  logic        busy  [2];

  logic [31:0] mdl [2][256];
  logic [31:0] last_rd [2];
  exp_t        sb0[$];
  exp_t        sb1[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // index 0: LATENCY=0, index 1: LATENCY=2
  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH_LOG2(8), .LATENCY(0)) u_dut_l0 (
    .i_clk(clk), .i_reset(rst_n), .i_addr_in(addr[0]), .i_wr_data(wdat[0]),
    .i_read_enable(rd_en[0]), .i_write_enable(wr_en[0]),
    .o_rd_data(rdat[0]), .o_cache_ready(rdy[0]), .o_err(err[0]), .o_busy(busy[0])
  );

  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH_LOG2(8), .LATENCY(2)) u_dut_l2 (
    .i_clk(clk), .i_reset(rst_n), .i_addr_in(addr[1]), .i_wr_data(wdat[1]),
    .i_read_enable(rd_en[1]), .i_write_enable(wr_en[1]),
    .o_rd_data(rdat[1]), .o_cache_ready(rdy[1]), .o_err(err[1]), .o_busy(busy[1])
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int s);
    return (s == 0) ? 0 : 2;
  endfunction

  // Expected response for a request, updating the reference array.
  function automatic exp_t predict(input int s, input bit rd, input bit wr,
                                   input logic [15:0] a, input logic [31:0] d);
    exp_t       e;
    logic [7:0] idx;
    idx   = a[7:0];
    e.cyc = 0;
    e.err = ((a >> 8) != 16'h0) || (rd && wr);
    if (rd) begin
      e.data     = e.err ? 32'h0 : mdl[s][idx];
      last_rd[s] = e.data;
    end else begin
      e.data = last_rd[s];
    end
    if (wr && !e.err) mdl[s][idx] = d;
    return e;
  endfunction

  task automatic push(input int s, input exp_t e);
    if (s == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic mon(input int s);
    exp_t  e;
    int    depth;
    string p;
    p     = (s == 0) ? "l0" : "l2";
    depth = (s == 0) ? sb0.size() : sb1.size();
    if (rdy[s]) begin
      if (depth == 0) begin
        check({p, "_unexpected_ready"}, 64'(rdy[s]), 64'h0);
      end else begin
        if (s == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        check({p, "_resp_cycle"}, 64'(cyc), 64'(e.cyc));
        check({p, "_rd_data"}, 64'(rdat[s]), 64'(e.data));
        check({p, "_err"}, 64'(err[s]), 64'(e.err));
      end
    end else begin
      check({p, "_err_without_ready"}, 64'(err[s]), 64'h0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  task automatic wait_idle(input int s, input int exp_busy);
    int n;
    n = 0;
    for (int i = 0; i < 20 && busy[s]; i++) begin
      n++;
      @(negedge clk);
    end
    if (exp_busy > 0) check("busy_cycles", 64'(n), 64'(exp_busy));
    check("back_to_idle", 64'(busy[s]), 64'h0);
  endtask

  // Called on a falling edge; one request sampled on the next rising edge.
  task automatic do_req(input int s, input bit rd, input bit wr,
                        input logic [15:0] a, input logic [31:0] d);
    exp_t e;
    e     = predict(s, rd, wr, a, d);
    e.cyc = cyc + 1 + lat_of(s);
    push(s, e);
    rd_en[s] = rd;
    wr_en[s] = wr;
    addr[s]  = a;
    wdat[s]  = d;
    @(negedge clk);
    rd_en[s] = 1'b0;
    wr_en[s] = 1'b0;
    wait_idle(s, lat_of(s) + 1);
  endtask

  task automatic check_quiet(input string tag, input int s);
    check(tag, {rdat[s], rdy[s], err[s], busy[s]}, 64'h0);
  endtask

  initial begin
    exp_t e;
    int   k;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rd_en[s] = 1'b0; wr_en[s] = 1'b0; addr[s] = '0; wdat[s] = '0; last_rd[s] = '0;
    end
    repeat (2) @(negedge clk);
    check_quiet("in_reset_l0", 0);
    check_quiet("in_reset_l2", 1);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_quiet("idle_after_reset_l0", 0);
      check_quiet("idle_after_reset_l2", 1);
    end

    do_req(1, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF);
    do_req(1, 1'b1, 1'b0, 16'h0010, 32'h0);

    // asynchronous reset in the middle of a high clock phase, request in flight
    rd_en[1] = 1'b1;
    addr[1]  = 16'h0010;
    @(posedge clk);
    #3;
    check("busy_before_async_reset", 64'(busy[1]), 64'h1);
    rst_n = 1'b0;
    #1;
    check_quiet("async_reset_l2", 1);
    check_quiet("async_reset_l0", 0);
    sb0.delete();
    sb1.delete();
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    rd_en[1] = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    do_req(1, 1'b0, 1'b1, 16'h0000, 32'h0BADF00D);
    do_req(1, 1'b0, 1'b1, 16'h0100, 32'hFFFFFFFF);
    do_req(1, 1'b1, 1'b0, 16'h0000, 32'h0);
    do_req(1, 1'b1, 1'b0, 16'h8000, 32'h0);

    do_req(1, 1'b0, 1'b1, 16'h0003, 32'h33334444);
    do_req(1, 1'b1, 1'b1, 16'h0003, 32'hCAFEF00D);
    do_req(1, 1'b1, 1'b0, 16'h0003, 32'h0);

    do_req(1, 1'b0, 1'b1, 16'h0020, 32'h11112222);
    do_req(1, 1'b1, 1'b0, 16'h0020, 32'h0);
    // aborted write: reset lands while the request is in WAIT
    wr_en[1] = 1'b1;
    addr[1]  = 16'h0020;
    wdat[1]  = 32'hA5A5A5A5;
    @(negedge clk);
    wr_en[1] = 1'b0;
    check("aborted_write_busy", 64'(busy[1]), 64'h1);
    rst_n = 1'b0;
    #1;
    check_quiet("reset_in_wait", 1);
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_ready_after_abort", 64'(rdy[1]), 64'h0);
    end
    do_req(1, 1'b1, 1'b0, 16'h0020, 32'h0);

    do_req(0, 1'b0, 1'b1, 16'h0005, 32'h12345678);
    do_req(0, 1'b1, 1'b0, 16'h0005, 32'h0);
    do_req(0, 1'b0, 1'b1, 16'h0200, 32'h0);
    // read level held high: a response every second cycle
    k = cyc;
    for (int i = 0; i < 4; i++) begin
      e     = predict(0, 1'b1, 1'b0, 16'h0005, 32'h0);
      e.cyc = k + 1 + 2 * i;
      push(0, e);
    end
    rd_en[0] = 1'b1;
    addr[0]  = 16'h0005;
    repeat (8) @(negedge clk);
    rd_en[0] = 1'b0;
    wait_idle(0, 0);
    repeat (2) @(negedge clk);

    check("scoreboard_drained", 64'(sb0.size() + sb1.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d)", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
